// File: rtl/uart_rx_deserializer_if.sv
`timescale 1ns/1ps
// uart_rx_deserializer_if
//   Bundles the serial input line and the received-frame level outputs of
//   uart_rx_deserializer.
//   rx      : raw serial line, idle high (driven by master)
//   data    : last received data byte (driven by slave)
//   parity  : parity bit as received (driven by slave)
//   ready   : 1 = idle / outputs valid, 0 = frame in progress (driven by slave)
//   error   : parity mismatch or low stop bit on last frame (driven by slave)
interface uart_rx_deserializer_if;
    logic       rx;
    logic [7:0] data;
    logic       parity;
    logic       ready;
    logic       error;

    modport master (output rx, input data, input parity, input ready, input error);
    modport slave  (input rx, output data, output parity, output ready, output error);
endinterface

// File: rtl/uart_rx_deserializer.sv
`timescale 1ns/1ps
// uart_rx_deserializer
//   8E1/8O1 UART receive front end. Synchronises the raw line, recovers
//   frames by OVERSAMPLE-times oversampling with mid-bit sampling, and
//   presents data / parity / ready / error as level outputs.
// Ports
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : uart_rx_deserializer_if.slave (rx in; data, parity, ready, error out)
module uart_rx_deserializer #(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned OVERSAMPLE = 16,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    uart_rx_deserializer_if.slave   bus
);

    localparam int unsigned TICK_DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int unsigned TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned SW       = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SAMP_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] SAMP_MID  = SW'(OVERSAMPLE / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
    } state_t;

    state_t        state_q,    state_d;
    logic          rx_meta_q,  rx_meta_d;
    logic          rx_sync_q,  rx_sync_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [SW-1:0] samp_cnt_q, samp_cnt_d;
    logic [2:0]    bit_idx_q,  bit_idx_d;
    logic [7:0]    shift_q,    shift_d;
    logic          par_bit_q,  par_bit_d;
    logic [7:0]    data_q,     data_d;
    logic          parity_q,   parity_d;
    logic          ready_q,    ready_d;
    logic          error_q,    error_d;

    logic          tick;
    logic          mid;
    logic [SW-1:0] samp_inc;

    always_comb begin
        state_d    = state_q;
        rx_meta_d  = bus.rx;
        rx_sync_d  = rx_meta_q;
        samp_cnt_d = samp_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        par_bit_d  = par_bit_q;
        data_d     = data_q;
        parity_d   = parity_q;
        ready_d    = ready_q;
        error_d    = error_q;

        tick       = (tick_cnt_q == TICK_LAST);
        tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
        mid        = (samp_cnt_q == SAMP_MID);
        samp_inc   = (samp_cnt_q == SAMP_LAST) ? '0 : samp_cnt_q + SW'(1);

        if (tick) begin
            case (state_q)
                S_IDLE: begin
                    // The detecting tick is sample 0 of the start bit.
                    if (!rx_sync_q) begin
                        samp_cnt_d = '0;
                        state_d    = S_START;
                    end
                end
                S_START: begin
                    samp_cnt_d = samp_inc;
                    if (mid) begin
                        if (rx_sync_q) begin
                            state_d = S_IDLE;
                        end else begin
                            ready_d   = 1'b0;
                            bit_idx_d = '0;
                            state_d   = S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    samp_cnt_d = samp_inc;
                    if (mid) begin
                        shift_d   = {rx_sync_q, shift_q[7:1]};
                        bit_idx_d = bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
                            state_d = S_PARITY;
                        end
                    end
                end
                S_PARITY: begin
                    samp_cnt_d = samp_inc;
                    if (mid) begin
                        par_bit_d = rx_sync_q;
                        state_d   = S_STOP;
                    end
                end
                S_STOP: begin
                    samp_cnt_d = samp_inc;
                    if (mid) begin
                        data_d   = shift_q;
                        parity_d = par_bit_q;
                        error_d  = !rx_sync_q || ((^{shift_q, par_bit_q}) != PARITY_ODD);
                        ready_d  = 1'b1;
                        // Leaving at mid-stop lets a start bit that follows
                        // immediately be caught.
                        state_d  = rx_sync_q ? S_IDLE : S_BREAK;
                    end
                end
                S_BREAK: begin
                    if (rx_sync_q) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            tick_cnt_q <= '0;
            samp_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            par_bit_q  <= 1'b0;
            data_q     <= '0;
            parity_q   <= 1'b0;
            ready_q    <= 1'b1;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rx_meta_q  <= rx_meta_d;
            rx_sync_q  <= rx_sync_d;
            tick_cnt_q <= tick_cnt_d;
            samp_cnt_q <= samp_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            par_bit_q  <= par_bit_d;
            data_q     <= data_d;
            parity_q   <= parity_d;
            ready_q    <= ready_d;
            error_q    <= error_d;
        end
    end

    assign bus.data   = data_q;
    assign bus.parity = parity_q;
    assign bus.ready  = ready_q;
    assign bus.error  = error_q;

endmodule
